// File: rtl/mips_dmem_responder.sv
// -----------------------------------------------------------------------------
// mips_dmem_responder
//
// Memory-side responder for the MIPS32 load/store path. The core issues one
// word request at a time on a valid/ready request channel; after a fixed
// LATENCY the single-port, word-addressed memory is accessed and (for loads)
// a response beat is offered on a valid/ready response channel.
// Addresses at or beyond DEPTH are flagged with rsp_err and never aliased
// onto in-range words.
//
// Parameters:
//   DATA_W  - data word width
//   DEPTH   - number of words; valid addresses are 0..DEPTH-1
//   LATENCY - clock edges from request acceptance to memory access (1..15)
//
// Ports:
//   clk1      in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req_valid in   request present
//   req_ready out  block can accept a request (IDLE only)
//   req_we    in   1 = store, 0 = load
//   req_addr  in   32-bit word address
//   req_wdata in   store data
//   rsp_valid out  response present
//   rsp_ready in   core accepts the response
//   rsp_rdata out  load data; 0 for stores and out-of-range accesses
//   rsp_err   out  address >= DEPTH
//   busy      out  high whenever the block is not IDLE
//
// Optional feature macro: DMEM_WR_ACK_EN
//   defined   - stores also produce one response beat (rsp_rdata = 0)
//   undefined - stores return from WAIT straight to IDLE with no response
// -----------------------------------------------------------------------------
module mips_dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef DMEM_WR_ACK_EN
  localparam logic STORE_ACK = 1'b1;
`else
  localparam logic STORE_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              busy_r;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range_s;
  logic              access_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  idx_s;

  // Full 32-bit compare so that any set upper address bit is rejected.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr < DEPTH_W);
  endfunction

  // Decode of the latched request: range check, word index, access strobe.
  always_comb begin
    in_range_s = addr_in_range(addr_r);
    idx_s      = addr_r[IDX_W-1:0];
    if ((state_r == S_WAIT) && (cnt_r == 4'd1)) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
    if (access_s && we_r && in_range_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array; never reset. The write strobe is derived from state_r, so
  // an asserted reset forces IDLE and discards any store not yet committed.
  always_ff @(posedge clk1) begin
    if (mem_we_s) begin
      mem[idx_s] <= wdata_r;
    end
  end

  // Request/response FSM with all handshake outputs registered.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            cnt_r       <= LAT_CNT;
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (access_s) begin
            // rsp_err is updated even for silently dropped stores.
            rsp_err_r <= ~in_range_s;
            if (!we_r && in_range_s) begin
              rsp_rdata_r <= mem[idx_s];
            end else begin
              rsp_rdata_r <= '0;
            end
            if (!we_r || STORE_ACK) begin
              rsp_valid_r <= 1'b1;
              state_r     <= S_RESP;
            end else begin
              req_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= S_IDLE;
            end
          end
        end
        S_RESP: begin
          // req_ready stays low through the handshake edge itself.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          cnt_r       <= 4'd0;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

endmodule
